pcm_stream_ctrl: RTL and testbench

Controller that sequences the PDM-decimated PCM stream into the byte-wide TX FIFO and serves that FIFO to the SPI slave. It sits between the decimator, the FIFO and `SPI_Slave`, and replaces ad-hoc glue in the top level. The SPI host controls it with command bytes: start/stop capture, flush, and status readback. Samples are always written to the FIFO as complete low/high byte pairs, so the host never sees a split sample.

---
 rtl/pcm_stream_pkg.sv | 23 ++
 rtl/sync_edge_detect.sv | 26 ++
 rtl/pcm_stream_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pcm_stream_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_stream_pkg.sv
// rtl/pcm_stream_pkg.sv - opcodes, FSM state types and constants for pcm_stream_ctrl
package pcm_stream_pkg;

  typedef enum logic [7:0] {
    CMD_START   = 8'hA1,
    CMD_STOP    = 8'hA2,
    CMD_FLUSH   = 8'hA3,
    CMD_STATUS  = 8'hA4,
    CMD_CLR_OVR = 8'hA5
  } cmd_e;

  typedef logic wr_state_t;
  localparam wr_state_t W_IDLE = 1'b0;
  localparam wr_state_t W_HIGH = 1'b1;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t R_IDLE = 2'd0;
  localparam rd_state_t R_WAIT = 2'd1;
  localparam rd_state_t R_LOAD = 2'd2;

  localparam logic [7:0] FILL_BYTE = 8'h00;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rising-edge pulse output
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/pcm_stream_ctrl.sv
// rtl/pcm_stream_ctrl.sv - packs PCM samples into the TX FIFO and serves it to the SPI slave
module pcm_stream_ctrl
  import pcm_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 524288,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pcm_data,
  input  logic                  pcm_valid,
  input  logic [7:0]            spi_cmd,
  input  logic                  spi_cmd_valid,
  input  logic                  spi_busy,
  output logic [7:0]            spi_tx_data,
  output logic                  spi_tx_valid,
  output logic                  fifo_wr_en,
  output logic [7:0]            fifo_wdata,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [7:0]            fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  fifo_flush,
  output logic                  capture_active,
  output logic [7:0]            overrun_cnt,
  output logic [LVL_W-1:0]      fifo_level
);

  localparam logic [LVL_W-1:0] LVL_LIMIT = LVL_W'(FIFO_DEPTH - 2);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);

  logic slot_edge;

  sync_edge_detect #(.STAGES(2)) u_busy_edge (
    .clk   (clk),
    .rst   (rst),
    .d_i   (spi_busy),
    .rise_o(slot_edge)
  );

  wr_state_t        wr_state_q, wr_state_d;
  rd_state_t        rd_state_q, rd_state_d;
  logic [7:0]       hi_q, hi_d, wdata_q, wdata_d, byte_q, byte_d;
  logic [7:0]       tx_data_q, tx_data_d, ovr_q, ovr_d;
  logic             wr_en_q, wr_en_d, rd_en_q, rd_en_d, tx_valid_q, tx_valid_d;
  logic             from_fifo_q, from_fifo_d, flush_pend_q, flush_pend_d;
  logic             flush_q, flush_d, capture_q, capture_d;
  logic [1:0]       status_cnt_q, status_cnt_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic cmd_start, cmd_stop, cmd_flush, cmd_status, cmd_clr_ovr;
  logic flush_fire, room_ok, ovr_inc;
  logic [7:0] status0;

  assign cmd_start   = spi_cmd_valid && (spi_cmd == CMD_START);
  assign cmd_stop    = spi_cmd_valid && (spi_cmd == CMD_STOP);
  assign cmd_flush   = spi_cmd_valid && (spi_cmd == CMD_FLUSH);
  assign cmd_status  = spi_cmd_valid && (spi_cmd == CMD_STATUS);
  assign cmd_clr_ovr = spi_cmd_valid && (spi_cmd == CMD_CLR_OVR);

  // Flush waits for the reader so an in-flight FIFO read is never cut off.
  assign flush_fire = (flush_pend_q | cmd_flush) & (rd_state_q == R_IDLE);
  // Room for a full pair, counting the byte being written this cycle.
  assign room_ok    = ~fifo_full &
                      ((level_q + {{(LVL_W-1){1'b0}}, wr_en_q}) <= LVL_LIMIT);
  assign status0    = {capture_q, fifo_empty, (ovr_q != 8'h00), 5'b0};

  always_comb begin
    wr_state_d   = wr_state_q;
    rd_state_d   = rd_state_q;
    hi_d         = hi_q;
    wdata_d      = wdata_q;
    byte_d       = byte_q;
    tx_data_d    = tx_data_q;
    ovr_d        = ovr_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    tx_valid_d   = 1'b0;
    from_fifo_d  = from_fifo_q;
    flush_pend_d = (flush_pend_q | cmd_flush) & ~flush_fire;
    flush_d      = flush_fire;
    capture_d    = cmd_start ? 1'b1 : (cmd_stop ? 1'b0 : capture_q);
    status_cnt_d = status_cnt_q;
    level_d      = level_q;
    ovr_inc      = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        if (pcm_valid && capture_q) begin
          if (room_ok) begin
            hi_d       = pcm_data[DATA_WIDTH-1:8];
            wdata_d    = pcm_data[7:0];
            wr_en_d    = 1'b1;
            wr_state_d = W_HIGH;
          end else begin
            ovr_inc = 1'b1;
          end
        end
      end
      W_HIGH: begin
        wdata_d    = hi_q;
        wr_en_d    = 1'b1;
        wr_state_d = W_IDLE;
        ovr_inc    = pcm_valid;
      end
    endcase

    if (flush_fire) begin
      wr_state_d = W_IDLE;
      wr_en_d    = 1'b0;
    end

    if (cmd_clr_ovr)
      ovr_d = 8'h00;
    else if (ovr_inc && (ovr_q != 8'hFF))
      ovr_d = ovr_q + 8'd1;

    if (flush_fire)
      level_d = '0;
    else if (wr_en_q && !rd_en_q)
      level_d = level_q + LVL_ONE;
    else if (!wr_en_q && rd_en_q)
      level_d = level_q - LVL_ONE;

    case (rd_state_q)
      R_IDLE: begin
        if (slot_edge) begin
          if (status_cnt_q != 2'd0) begin
            byte_d       = (status_cnt_q == 2'd2) ? status0 : ovr_q;
            status_cnt_d = status_cnt_q - 2'd1;
            from_fifo_d  = 1'b0;
            rd_state_d   = R_LOAD;
          end else if (!fifo_empty && !flush_fire) begin
            rd_en_d     = 1'b1;
            from_fifo_d = 1'b1;
            rd_state_d  = R_WAIT;
          end else begin
            byte_d      = FILL_BYTE;
            from_fifo_d = 1'b0;
            rd_state_d  = R_LOAD;
          end
        end
      end
      R_WAIT: rd_state_d = R_LOAD;
      R_LOAD: begin
        tx_data_d  = from_fifo_q ? fifo_rdata : byte_q;
        tx_valid_d = 1'b1;
        rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase

    if (cmd_status)
      status_cnt_d = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q   <= W_IDLE;
      rd_state_q   <= R_IDLE;
      hi_q         <= 8'h00;
      wdata_q      <= 8'h00;
      byte_q       <= 8'h00;
      tx_data_q    <= 8'h00;
      ovr_q        <= 8'h00;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      tx_valid_q   <= 1'b0;
      from_fifo_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_q      <= 1'b0;
      capture_q    <= 1'b0;
      status_cnt_q <= 2'd0;
      level_q      <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      hi_q         <= hi_d;
      wdata_q      <= wdata_d;
      byte_q       <= byte_d;
      tx_data_q    <= tx_data_d;
      ovr_q        <= ovr_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      tx_valid_q   <= tx_valid_d;
      from_fifo_q  <= from_fifo_d;
      flush_pend_q <= flush_pend_d;
      flush_q      <= flush_d;
      capture_q    <= capture_d;
      status_cnt_q <= status_cnt_d;
      level_q      <= level_d;
    end
  end

  assign spi_tx_data    = tx_data_q;
  assign spi_tx_valid   = tx_valid_q;
  assign fifo_wr_en     = wr_en_q;
  assign fifo_wdata     = wdata_q;
  assign fifo_rd_en     = rd_en_q;
  assign fifo_flush     = flush_q;
  assign capture_active = capture_q;
  assign overrun_cnt    = ovr_q;
  assign fifo_level     = level_q;

endmodule

// File: tb/tb_pcm_stream_ctrl.sv
// tb/tb_pcm_stream_ctrl.sv - directed self-checking bench for pcm_stream_ctrl
module tb_pcm_stream_ctrl;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk, rst;
  logic [15:0]   pcm_data;
  logic          pcm_valid;
  logic [7:0]    spi_cmd;
  logic          spi_cmd_valid, spi_busy;
  logic [7:0]    spi_tx_data;
  logic          spi_tx_valid, fifo_wr_en, fifo_rd_en, fifo_flush, capture_active;
  logic [7:0]    fifo_wdata, fifo_rdata, overrun_cnt;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  pcm_stream_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pcm_data(pcm_data), .pcm_valid(pcm_valid),
    .spi_cmd(spi_cmd), .spi_cmd_valid(spi_cmd_valid), .spi_busy(spi_busy),
    .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_flush(fifo_flush), .capture_active(capture_active),
    .overrun_cnt(overrun_cnt), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte FIFO model with registered read data.
  logic [7:0] mem[$];
  logic [7:0] wr_log[$];
  int         fifo_cnt = 0;

  assign fifo_empty = (fifo_cnt == 0);
  assign fifo_full  = (fifo_cnt >= DEPTH);

  initial fifo_rdata = 8'h00;

  always @(posedge clk) begin
    if (fifo_flush) begin
      mem.delete();
      fifo_cnt <= 0;
    end else begin
      if (fifo_rd_en && mem.size() > 0) fifo_rdata <= mem.pop_front();
      if (fifo_wr_en) begin
        mem.push_back(fifo_wdata);
        wr_log.push_back(fifo_wdata);
      end
      fifo_cnt <= fifo_cnt + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && fifo_cnt > 0) ? 1 : 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    spi_cmd       = b;
    spi_cmd_valid = 1'b1;
    tick();
    spi_cmd_valid = 1'b0;
  endtask

  task automatic push_sample(input string tag, input logic [15:0] d, input logic accept);
    pcm_data  = d;
    pcm_valid = 1'b1;
    tick();
    pcm_valid = 1'b0;
    check_eq({tag, "_wr_lo"}, 32'(fifo_wr_en), 32'(accept));
    if (accept) check_eq({tag, "_lo"}, 32'(fifo_wdata), 32'(d[7:0]));
    tick();
    check_eq({tag, "_wr_hi"}, 32'(fifo_wr_en), 32'(accept));
    if (accept) check_eq({tag, "_hi"}, 32'(fifo_wdata), 32'(d[15:8]));
  endtask

  task automatic run_slot(output logic [7:0] data, output int tx_cyc, output int rd_cyc);
    data   = 8'h00;
    tx_cyc = -1;
    rd_cyc = -1;
    spi_busy = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (fifo_rd_en && rd_cyc < 0) rd_cyc = i;
      if (spi_tx_valid) begin
        data   = spi_tx_data;
        tx_cyc = i;
        break;
      end
    end
    spi_busy = 1'b0;
    repeat (4) tick();
  endtask

  logic [7:0] sd;
  int         stx, srd;
  logic [7:0] exp_bytes [6];

  initial begin
    exp_bytes = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00};
    rst = 1'b1; pcm_data = '0; pcm_valid = 1'b0;
    spi_cmd = '0; spi_cmd_valid = 1'b0; spi_busy = 1'b0;
    #12;
    check_eq("rst_capture", 32'(capture_active), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_txv", 32'(spi_tx_valid), 32'd0);
    check_eq("rst_ovr", 32'(overrun_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Empty FIFO: fill bytes, no reads.
    for (int k = 0; k < 2; k++) begin
      run_slot(sd, stx, srd);
      check_eq("empty_data", 32'(sd), 32'h00);
      check_eq("empty_txcyc", 32'(stx), 32'd4);
      check_eq("empty_norden", 32'(srd), 32'hFFFF_FFFF);
    end

    send_cmd(8'hA1);
    check_eq("start_capture", 32'(capture_active), 32'd1);
    push_sample("s0", 16'h1234, 1'b1);
    push_sample("s1", 16'hABCD, 1'b1);
    push_sample("s2", 16'h00FF, 1'b1);
    tick();
    check_eq("level6", 32'(fifo_level), 32'd6);
    check_eq("log_size", 32'(wr_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < wr_log.size()) check_eq("log_byte", 32'(wr_log[i]), 32'(exp_bytes[i]));

    // Fill to DEPTH, read one back, then a sample at DEPTH-1 must be dropped.
    push_sample("s3", 16'h5566, 1'b1);
    tick();
    check_eq("level8", 32'(fifo_level), 32'd8);
    run_slot(sd, stx, srd);
    check_eq("rd_data", 32'(sd), 32'h34);
    check_eq("rd_txcyc", 32'(stx), 32'd5);
    check_eq("rd_rdcyc", 32'(srd), 32'd3);
    check_eq("level7", 32'(fifo_level), 32'd7);
    push_sample("drop", 16'h7777, 1'b0);
    check_eq("ovr1", 32'(overrun_cnt), 32'd1);
    check_eq("level7b", 32'(fifo_level), 32'd7);

    send_cmd(8'hA4);
    run_slot(sd, stx, srd);
    check_eq("status0", 32'(sd), 32'hA0);
    check_eq("status0_cyc", 32'(stx), 32'd4);
    check_eq("status0_nord", 32'(srd), 32'hFFFF_FFFF);
    run_slot(sd, stx, srd);
    check_eq("status1", 32'(sd), 32'h01);

    // FLUSH issued while the reader sits in R_WAIT.
    spi_busy = 1'b1;
    tick(); tick(); tick();
    check_eq("fl_rden", 32'(fifo_rd_en), 32'd1);
    spi_cmd = 8'hA3; spi_cmd_valid = 1'b1;
    tick();
    spi_cmd_valid = 1'b0;
    check_eq("fl_c4", 32'(fifo_flush), 32'd0);
    tick();
    check_eq("fl_txv", 32'(spi_tx_valid), 32'd1);
    check_eq("fl_txd", 32'(spi_tx_data), 32'h12);
    check_eq("fl_c5", 32'(fifo_flush), 32'd0);
    tick();
    check_eq("fl_c6", 32'(fifo_flush), 32'd1);
    check_eq("fl_level", 32'(fifo_level), 32'd0);
    tick();
    check_eq("fl_c7", 32'(fifo_flush), 32'd0);
    spi_busy = 1'b0;
    repeat (4) tick();
    run_slot(sd, stx, srd);
    check_eq("fl_fill", 32'(sd), 32'h00);
    check_eq("fl_norden", 32'(srd), 32'hFFFF_FFFF);

    // Back-to-back samples with STOP landing in W_HIGH.
    send_cmd(8'hA5);
    check_eq("clr_ovr", 32'(overrun_cnt), 32'd0);
    pcm_data = 16'h7788; pcm_valid = 1'b1;
    tick();
    check_eq("b2b_lo", 32'(fifo_wdata), 32'h88);
    pcm_data = 16'h9999;
    spi_cmd = 8'hA2; spi_cmd_valid = 1'b1;
    tick();
    pcm_valid = 1'b0; spi_cmd_valid = 1'b0;
    check_eq("b2b_wr_hi", 32'(fifo_wr_en), 32'd1);
    check_eq("b2b_hi", 32'(fifo_wdata), 32'h77);
    check_eq("b2b_stop", 32'(capture_active), 32'd0);
    check_eq("b2b_ovr", 32'(overrun_cnt), 32'd1);
    tick();
    check_eq("b2b_idle", 32'(fifo_wr_en), 32'd0);
    check_eq("b2b_level", 32'(fifo_level), 32'd2);

    // Read and write strobes coincide: level holds.
    send_cmd(8'hA1);
    spi_busy = 1'b1;
    tick(); tick();
    pcm_data = 16'h0102; pcm_valid = 1'b1;
    tick();
    pcm_valid = 1'b0;
    check_eq("rw_rden", 32'(fifo_rd_en), 32'd1);
    check_eq("rw_wren", 32'(fifo_wr_en), 32'd1);
    check_eq("rw_lvl3", 32'(fifo_level), 32'd2);
    tick();
    check_eq("rw_lvl4", 32'(fifo_level), 32'd2);
    tick();
    check_eq("rw_lvl5", 32'(fifo_level), 32'd3);
    check_eq("rw_txd", 32'(spi_tx_data), 32'h88);
    spi_busy = 1'b0;
    repeat (4) tick();

    // Asynchronous reset in the middle of a pair.
    pcm_data = 16'hBEEF; pcm_valid = 1'b1;
    tick();
    pcm_valid = 1'b0;
    check_eq("mid_wr_lo", 32'(fifo_wr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_wren", 32'(fifo_wr_en), 32'd0);
    check_eq("arst_wdata", 32'(fifo_wdata), 32'd0);
    check_eq("arst_level", 32'(fifo_level), 32'd0);
    check_eq("arst_cap", 32'(capture_active), 32'd0);
    check_eq("arst_txd", 32'(spi_tx_data), 32'd0);
    #2 rst = 1'b0;
    tick();
    check_eq("post_rst_wren", 32'(fifo_wr_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
